// File: rtl/logic_engine_pkg.sv
// Shared types for the logic-engine arbiter: opcode map and FSM state encoding.
package logic_engine_pkg;

    // Opcode map for the shared 8-bit logic unit
    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_NAND = 2'b01,
        OP_NOR  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_rr_arbiter.sv
// Request arbiter for logic_engine_arbiter.
// Default build: round-robin with an internal pointer that moves past each winner.
// With LOGIC_ARB_FIXED_PRIO_EN defined: lowest asserted index wins, no pointer.
module logic_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic            any_s;
    logic [ID_W-1:0] idx_s;

    assign any_s = |req_i;

`ifdef LOGIC_ARB_FIXED_PRIO_EN

    logic unused_s;
    assign unused_s = ^{clk, rst, adv_i};

    // Lowest-index search: scan downwards so the smallest set index is written last
    always_comb begin
        idx_s = {ID_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = req_i[k] ? ID_W'(k) : idx_s;
        end
    end

`else

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // Rotating search from ptr_q: scan offsets downwards so the nearest hit wins
    always_comb begin
        idx_s = {ID_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int pos_v;
            pos_v = int'(ptr_q) + k;
            pos_v = (pos_v >= NUM_REQ) ? (pos_v - NUM_REQ) : pos_v;
            idx_s = req_i[pos_v] ? ID_W'(pos_v) : idx_s;
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NUM_REQ-1
    always_comb begin
        if (idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_d = {ID_W{1'b0}};
        end else begin
            ptr_d = idx_s + ID_W'(1);
        end
    end

    // Pointer register; only advances on an actual grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {ID_W{1'b0}};
        end else if (adv_i && any_s) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

`endif

    // One-hot grant from the encoded winner; zero when nothing is requested
    always_comb begin
        if (any_s) begin
            gnt_o = NUM_REQ'(1) << idx_s;
        end else begin
            gnt_o = {NUM_REQ{1'b0}};
        end
    end

    assign idx_o = idx_s;

endmodule

// File: rtl/logic_engine_arbiter.sv
// Shares one logic-function unit between NUM_REQ requesters.
// IDLE grants and latches one request, EXEC evaluates into the result register,
// RESP holds the result until the consumer takes it.
// Build option: LOGIC_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module logic_engine_arbiter
    import logic_engine_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    op_e                 op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]  req_gated_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]     arb_idx_s;
    logic                idle_s;
    logic                accept_s;

    assign idle_s   = (state_q == IDLE);
    assign accept_s = |gnt_s;

    // Requests are only visible to the arbiter in IDLE and outside reset
    always_comb begin
        if (idle_s && !rst) begin
            req_gated_s = req_valid;
        end else begin
            req_gated_s = {NUM_REQ{1'b0}};
        end
    end

    logic_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_gated_s),
        .adv_i (idle_s),
        .gnt_o (gnt_s),
        .idx_o (arb_idx_s)
    );

    // Next-state, operand latch and result evaluation
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = req_a[int'(arb_idx_s)*DATA_W +: DATA_W];
                    b_d     = req_b[int'(arb_idx_s)*DATA_W +: DATA_W];
                    op_d    = op_e'(req_op[int'(arb_idx_s)*2 +: 2]);
                    id_d    = arb_idx_s;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_OR:   rsp_data_d = a_q | b_q;
                    OP_NAND: rsp_data_d = ~(a_q & b_q);
                    OP_NOR:  rsp_data_d = ~(a_q | b_q);
                    OP_AND:  rsp_data_d = a_q & b_q;
                    default: rsp_data_d = {DATA_W{1'b0}};
                endcase
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                // Illegal encoding: drop anything in flight and recover to IDLE
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {DATA_W{1'b0}};
            b_q         <= {DATA_W{1'b0}};
            op_q        <= OP_OR;
            id_q        <= {ID_W{1'b0}};
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_id_q    <= {ID_W{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = gnt_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = !idle_s;

endmodule

// File: tb/tb_logic_engine_arbiter.sv
// Directed self-checking bench for logic_engine_arbiter (NUM_REQ=4, DATA_W=8).
// Expectations follow LOGIC_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_logic_engine_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks_r;
    int errors_r;

    logic_engine_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_payload(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_op[i*2 +: 2] = op;
    endtask

    // Applies reset for two cycles with the given request vector present; checks outputs at the end
    task automatic do_reset(input logic [3:0] vec);
        rst       = 1'b1;
        req_valid = vec;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'h0);
        check_eq("rst_rsp_id",    32'(rsp_id),    32'h0);
        check_eq("rst_busy",      32'(busy),      32'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;
    endtask

    // One full transaction with rsp_ready=1; starts and ends at a negedge in IDLE
    task automatic run_txn(input string tag, input logic [3:0] vec, input logic [3:0] exp_gnt,
                           input logic [7:0] exp_data, input logic [1:0] exp_id, input logic keep);
        req_valid = vec;
        rsp_ready = 1'b1;
        #1;
        check_eq({tag, "_grant"}, 32'(req_ready), 32'(exp_gnt));
        @(negedge clk);
        if (!keep) req_valid = 4'b0000;
        #1;
        check_eq({tag, "_exec_ready"}, 32'(req_ready), 32'h0);
        check_eq({tag, "_exec_busy"},  32'(busy),      32'h1);
        check_eq({tag, "_exec_valid"}, 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        check_eq({tag, "_data"},  32'(rsp_data),  32'(exp_data));
        check_eq({tag, "_id"},    32'(rsp_id),    32'(exp_id));
        @(negedge clk);
        check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
        check_eq({tag, "_done_busy"},  32'(busy),      32'h0);
    endtask

    logic [1:0] exp_ids [5];
    logic       seen_rsp;

    initial begin
        checks_r  = 0;
        errors_r  = 0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        req_op    = 8'h0;
        rsp_ready = 1'b1;
        @(negedge clk);

        // Reset with all requests pending: nothing granted
        do_reset(4'b1111);

        // Single request from requester 2: OR of F0/3C
        set_payload(2, 8'hF0, 8'h3C, 2'b00);
        run_txn("single", 4'b0100, 4'b0100, 8'hFC, 2'd2, 1'b0);

        // All opcodes through requester 0 (ptr wraps from 3 to 0 in round-robin)
        set_payload(0, 8'hAA, 8'h0F, 2'b00);
        run_txn("op_or", 4'b0001, 4'b0001, 8'hAF, 2'd0, 1'b0);
        set_payload(0, 8'hAA, 8'h0F, 2'b01);
        run_txn("op_nand", 4'b0001, 4'b0001, 8'hF5, 2'd0, 1'b0);
        set_payload(0, 8'hAA, 8'h0F, 2'b10);
        run_txn("op_nor", 4'b0001, 4'b0001, 8'h50, 2'd0, 1'b0);
        set_payload(0, 8'hAA, 8'h0F, 2'b11);
        run_txn("op_and", 4'b0001, 4'b0001, 8'h0A, 2'd0, 1'b0);

        // Fairness: requester i returns 8'h11*(i+1)
        do_reset(4'b0000);
        for (int i = 0; i < 4; i++) set_payload(i, 8'(8'h11 * (i + 1)), 8'h00, 2'b00);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int t = 0; t < 5; t++) begin
            run_txn($sformatf("fair%0d", t), 4'b1111, 4'(4'b0001 << exp_ids[t]),
                    8'(8'h11 * (int'(exp_ids[t]) + 1)), exp_ids[t], 1'b1);
        end

        // Backpressure: requester 3 accepted, requester 1 waits, 5 stalled RESP cycles
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check_eq("bp_exec_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("bp_data%0d", c),  32'(rsp_data),  32'h44);
            check_eq($sformatf("bp_id%0d", c),    32'(rsp_id),    32'h3);
            check_eq($sformatf("bp_ready%0d", c), 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        check_eq("bp_hold_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_after_valid", 32'(rsp_valid), 32'h0);
        check_eq("bp_after_busy",  32'(busy),      32'h0);
        check_eq("bp_next_grant",  32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("bp_next_valid", 32'(rsp_valid), 32'h1);
        check_eq("bp_next_data",  32'(rsp_data),  32'h22);
        check_eq("bp_next_id",    32'(rsp_id),    32'h1);
        @(negedge clk);

        // Reset during EXEC: the in-flight request must never respond
        req_valid = 4'b0100;
        #1;
        check_eq("mid_grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        check_eq("mid_in_exec", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("mid_rsp_data",  32'(rsp_data),  32'h0);
        check_eq("mid_rsp_id",    32'(rsp_id),    32'h0);
        check_eq("mid_busy",      32'(busy),      32'h0);
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen_rsp = seen_rsp | rsp_valid;
        end
        check_eq("mid_no_rsp", 32'(seen_rsp), 32'h0);
        run_txn("mid_next", 4'b1111, 4'b0001, 8'h11, 2'd0, 1'b0);

        // Sparse: after grant to 2, only requester 1 pending, then ptr must sit at 2
        do_reset(4'b0000);
        run_txn("sp_g2", 4'b0100, 4'b0100, 8'h33, 2'd2, 1'b0);
        run_txn("sp_g1", 4'b0010, 4'b0010, 8'h22, 2'd1, 1'b0);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        run_txn("sp_ptr", 4'b0110, 4'b0010, 8'h22, 2'd1, 1'b0);
`else
        run_txn("sp_ptr", 4'b0110, 4'b0100, 8'h33, 2'd2, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
